// File: rtl/bin2bcd_if.sv
// ---------------------------------------------------------------------------
// bin2bcd_if
// Handshake bundle for the sequential binary-to-BCD converter.
//   in_valid  : producer has a word on hex
//   in_ready  : converter can take a word this cycle
//   hex       : sign (bit DATA_W) plus two's-complement low bits
//   out_valid : dec/neg/ovf carry a finished result, held until accepted
//   out_ready : consumer takes the result this cycle
//   dec       : packed BCD, digit 0 (units) in bits 3:0
//   neg       : result is negative with non-zero magnitude
//   ovf       : magnitude did not fit in DIGITS digits (dec is modulo)
// master = producer/consumer side, slave = converter side.
// ---------------------------------------------------------------------------
interface bin2bcd_if #(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W:0]       hex;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   dec;
    logic                  neg;
    logic                  ovf;

    modport master (
        output in_valid, hex, out_ready,
        input  in_ready, out_valid, dec, neg, ovf
    );

    modport slave (
        input  in_valid, hex, out_ready,
        output in_ready, out_valid, dec, neg, ovf
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Iterative sign-magnitude binary-to-BCD converter (double dabble), one
// magnitude bit per clock. A word accepted on edge k is presented with
// out_valid=1 after edge k+DATA_W and held until out_ready.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears all state
//   bus   : bin2bcd_if slave (in_valid/in_ready/hex in,
//           out_valid/out_ready/dec/neg/ovf out)
// ---------------------------------------------------------------------------
module bin2bcd_seq #(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    bin2bcd_if.slave bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [DATA_W-1:0] MAG_ONE  = DATA_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Add 3 to every digit that is 5 or more, so the following left shift
    // carries into the next digit exactly when the doubled digit reaches 10.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Negative inputs are negated in DATA_W bits, so -2^DATA_W wraps to 0
    // and the most negative low pattern gives 2^(DATA_W-1).
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W:0] h);
        if (h[DATA_W]) begin
            return ~h[DATA_W-1:0] + MAG_ONE;
        end
        return h[DATA_W-1:0];
    endfunction

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] bin_q,   bin_d;
    logic [BCD_W-1:0]  bcd_q,   bcd_d;
    logic              neg_q,   neg_d;
    logic              ovf_q,   ovf_d;

    logic              in_ready_c;
    logic              accept_c;
    logic [BCD_W-1:0]  bcd_adj_c;
    logic [DATA_W-1:0] mag_c;

    // in_ready depends only on state and out_ready, never on in_valid.
    assign in_ready_c = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign accept_c   = in_ready_c && bus.in_valid;

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == DONE);
    assign bus.dec       = bcd_q;
    assign bus.neg       = neg_q;
    assign bus.ovf       = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        bcd_adj_c = add3_digits(bcd_q);
        mag_c     = magnitude(bus.hex);

        case (state_q)
            IDLE, DONE: begin
                if (accept_c) begin
                    state_d = CONV;
                    cnt_d   = CNT_LOAD;
                    bin_d   = mag_c;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    neg_d   = bus.hex[DATA_W] && (mag_c != '0);
                end else if ((state_q == DONE) && bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                // Shift {BCD, bin} left by one; the bit leaving the top digit
                // is a carry worth 10^DIGITS and marks overflow.
                bcd_d = {bcd_adj_c[BCD_W-2:0], bin_q[DATA_W-1]};
                bin_d = {bin_q[DATA_W-2:0], 1'b0};
                ovf_d = ovf_q | bcd_adj_c[BCD_W-1];
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bin2bcd_if #(.DATA_W(16), .DIGITS(5)) ifa ();
    bin2bcd_if #(.DATA_W(16), .DIGITS(4)) ifb ();
    bin2bcd_if #(.DATA_W(12), .DIGITS(4)) ifc ();

    bin2bcd_seq #(.DATA_W(16), .DIGITS(5)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    bin2bcd_seq #(.DATA_W(16), .DIGITS(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    bin2bcd_seq #(.DATA_W(12), .DIGITS(4)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [19:0] dec;
        logic        neg;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    function automatic int dw_of(input int w);
        return (w == 2) ? 12 : 16;
    endfunction

    function automatic int dg_of(input int w);
        return (w == 0) ? 5 : 4;
    endfunction

    // Reference: arithmetic negation modulo 2^dw, decimal digits by division.
    function automatic exp_t model(input int w, input logic [16:0] h);
        exp_t   e;
        int     dw, dg;
        longint mask, low, mag, lim, rem;
        logic   sign;
        dw   = dw_of(w);
        dg   = dg_of(w);
        mask = (longint'(1) << dw) - 1;
        low  = longint'(h) & mask;
        sign = h[dw];
        mag  = sign ? (((longint'(1) << dw) - low) & mask) : low;
        lim  = 1;
        for (int i = 0; i < dg; i++) lim = lim * 10;
        e.ovf = (mag >= lim);
        e.neg = sign && (mag != 0);
        rem   = mag % lim;
        e.dec = '0;
        for (int i = 0; i < dg; i++) begin
            e.dec[4*i +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return e;
    endfunction

    task automatic drive(input int w, input logic v, input logic [16:0] h, input logic r);
        case (w)
            0: begin ifa.in_valid = v; ifa.hex = h;        ifa.out_ready = r; end
            1: begin ifb.in_valid = v; ifb.hex = h;        ifb.out_ready = r; end
            default: begin ifc.in_valid = v; ifc.hex = h[12:0]; ifc.out_ready = r; end
        endcase
    endtask

    task automatic get(input int w, output logic irdy, output logic ov,
                       output logic [19:0] d, output logic n, output logic o);
        case (w)
            0: begin irdy = ifa.in_ready; ov = ifa.out_valid; d = ifa.dec;
                     n = ifa.neg; o = ifa.ovf; end
            1: begin irdy = ifb.in_ready; ov = ifb.out_valid; d = 20'(ifb.dec);
                     n = ifb.neg; o = ifb.ovf; end
            default: begin irdy = ifc.in_ready; ov = ifc.out_valid; d = 20'(ifc.dec);
                     n = ifc.neg; o = ifc.ovf; end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one word, scramble hex while converting, check latency and result.
    task automatic convert(input int w, input logic [16:0] h, input string name,
                           output logic ovf_seen);
        logic irdy, ov, n, o;
        logic [19:0] d;
        int k, lat;
        exp_t e;
        ovf_seen = 1'b0;
        get(w, irdy, ov, d, n, o);
        k = 0;
        while (!irdy && k < 50) begin tick(); get(w, irdy, ov, d, n, o); k++; end
        checks++;
        if (irdy !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready: got %b expected 1", name, irdy);
        end
        drive(w, 1'b1, h, 1'b0);
        sb.push_back(model(w, h));
        tick();
        drive(w, 1'b0, ~h, 1'b0);
        lat = 0;
        get(w, irdy, ov, d, n, o);
        while (!ov && lat < 64) begin tick(); lat++; get(w, irdy, ov, d, n, o); end
        e = sb.pop_front();
        checks++;
        if (lat !== dw_of(w)) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, dw_of(w));
        end
        checks++;
        if (d !== e.dec) begin
            errors++;
            $display("FAIL %s dec: got %h expected %h", name, d, e.dec);
        end
        checks++;
        if (n !== e.neg) begin
            errors++;
            $display("FAIL %s neg: got %b expected %b", name, n, e.neg);
        end
        checks++;
        if (o !== e.ovf) begin
            errors++;
            $display("FAIL %s ovf: got %b expected %b", name, o, e.ovf);
        end
        ovf_seen = o;
        drive(w, 1'b0, ~h, 1'b1);
        tick();
        drive(w, 1'b0, ~h, 1'b0);
        get(w, irdy, ov, d, n, o);
        checks++;
        if (ov !== 1'b0) begin
            errors++;
            $display("FAIL %s out_valid after accept: got %b expected 0", name, ov);
        end
    endtask

    task automatic test_reset();
        logic irdy, ov, n, o;
        logic [19:0] d;
        rst_n = 1'b0;
        for (int w = 0; w < 3; w++) drive(w, 1'b0, 17'h0, 1'b0);
        #22;
        for (int w = 0; w < 3; w++) begin
            get(w, irdy, ov, d, n, o);
            checks++;
            if (irdy !== 1'b1 || ov !== 1'b0) begin
                errors++;
                $display("FAIL reset handshake[%0d]: got rdy=%b vld=%b expected rdy=1 vld=0",
                         w, irdy, ov);
            end
            checks++;
            if (d !== 20'h0 || n !== 1'b0 || o !== 1'b0) begin
                errors++;
                $display("FAIL reset outputs[%0d]: got dec=%h neg=%b ovf=%b expected 0/0/0",
                         w, d, n, o);
            end
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sign();
        logic [16:0] vals[5];
        logic os;
        vals = '{17'h03039, 17'h1FFFF, 17'h18000, 17'h10000, 17'h0FFFF};
        foreach (vals[i]) convert(0, vals[i], $sformatf("sign_%h", vals[i]), os);
    endtask

    task automatic test_overflow();
        logic os;
        convert(1, 17'h03039, "ovf_12345", os);
        convert(1, 17'h0270F, "ovf_9999", os);
    endtask

    task automatic test_back_to_back();
        logic irdy, ov, n, o;
        logic [19:0] d;
        int lat;
        exp_t e;
        drive(0, 1'b1, 17'h0D431, 1'b0);
        sb.push_back(model(0, 17'h0D431));
        tick();
        drive(0, 1'b0, 17'h0, 1'b0);
        lat = 0;
        get(0, irdy, ov, d, n, o);
        while (!ov && lat < 64) begin tick(); lat++; get(0, irdy, ov, d, n, o); end
        e = sb.pop_front();
        checks++;
        if (ov !== 1'b1 || d !== e.dec) begin
            errors++;
            $display("FAIL b2b first: got vld=%b dec=%h expected vld=1 dec=%h", ov, d, e.dec);
        end
        for (int c = 0; c < 10; c++) begin
            drive(0, 1'b0, 17'(c), 1'b0);
            tick();
            get(0, irdy, ov, d, n, o);
            checks++;
            if (ov !== 1'b1 || irdy !== 1'b0 || d !== e.dec || n !== e.neg || o !== e.ovf) begin
                errors++;
                $display("FAIL hold cycle %0d: got vld=%b rdy=%b dec=%h neg=%b ovf=%b expected 1 0 %h %b %b",
                         c, ov, irdy, d, n, o, e.dec, e.neg, e.ovf);
            end
        end
        drive(0, 1'b1, 17'h00007, 1'b1);
        #1;
        get(0, irdy, ov, d, n, o);
        checks++;
        if (irdy !== 1'b1) begin
            errors++;
            $display("FAIL b2b in_ready: got %b expected 1", irdy);
        end
        sb.push_back(model(0, 17'h00007));
        @(posedge clk);
        #1;
        drive(0, 1'b0, 17'h1FFFF, 1'b0);
        get(0, irdy, ov, d, n, o);
        checks++;
        if (ov !== 1'b0) begin
            errors++;
            $display("FAIL b2b reload: got out_valid=%b expected 0", ov);
        end
        lat = 0;
        while (!ov && lat < 64) begin tick(); lat++; get(0, irdy, ov, d, n, o); end
        e = sb.pop_front();
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL b2b latency: got %0d expected 16", lat);
        end
        checks++;
        if (d !== e.dec || n !== e.neg || o !== e.ovf) begin
            errors++;
            $display("FAIL b2b second: got %h/%b/%b expected %h/%b/%b", d, n, o, e.dec, e.neg, e.ovf);
        end
        drive(0, 1'b0, 17'h0, 1'b1);
        tick();
        drive(0, 1'b0, 17'h0, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic irdy, ov, n, o, stale;
        logic [19:0] d;
        drive(0, 1'b1, 17'h03039, 1'b0);
        tick();
        drive(0, 1'b0, 17'h0, 1'b0);
        for (int c = 0; c < 5; c++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        get(0, irdy, ov, d, n, o);
        checks++;
        if (ov !== 1'b0 || d !== 20'h0) begin
            errors++;
            $display("FAIL mid reset: got vld=%b dec=%h expected 0/00000", ov, d);
        end
        #3;
        rst_n = 1'b1;
        #1;
        get(0, irdy, ov, d, n, o);
        checks++;
        if (irdy !== 1'b1) begin
            errors++;
            $display("FAIL mid reset in_ready: got %b expected 1", irdy);
        end
        stale = 1'b0;
        drive(0, 1'b0, 17'h0, 1'b1);
        for (int c = 0; c < 30; c++) begin
            tick();
            get(0, irdy, ov, d, n, o);
            if (ov !== 1'b0 || d !== 20'h0) stale = 1'b1;
        end
        drive(0, 1'b0, 17'h0, 1'b0);
        checks++;
        if (stale !== 1'b0) begin
            errors++;
            $display("FAIL stale result: got %b expected 0", stale);
        end
    endtask

    task automatic test_random();
        logic [16:0] corners[4];
        logic [16:0] h;
        logic os;
        corners = '{17'h01000, 17'h01800, 17'h00FFF, 17'h01FFF};
        for (int i = 0; i < 44; i++) begin
            h = (i < 4) ? corners[i] : 17'($urandom_range(0, 8191));
            convert(2, h, $sformatf("rand_%h", h), os);
            checks++;
            if (os !== 1'b0) begin
                errors++;
                $display("FAIL rand ovf %h: got %b expected 0", h, os);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sign();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Parametrised sign-magnitude binary-to-BCD converter for the MPPT fitness/display path. It replaces the fixed 16-bit table-lookup converter with an iterative shift-add-3 (double-dabble) engine of configurable width and digit count, and adds a valid/ready handshake, a sign output and an overflow flag. It sits between the fitness-value computation and the display/UART formatting logic. The design trades latency (one cycle per magnitude bit) for area.

## Interface
- DATA_W, 16: magnitude width in bits; legal range 4..32.
- DIGITS, 5: BCD output digits; legal range 1..10. Smaller values than ceil(DATA_W·log10 2) are legal and exercise the overflow path.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; all state cleared while low.
- in_valid  in  1  input word valid.
- in_ready  out  1  converter can accept a word.
- hex  in  DATA_W+1  input word; bit DATA_W is the sign, bits DATA_W-1:0 are two's-complement low bits.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts result.
- dec  out  4·DIGITS  packed BCD; digit 0 (units) in bits 3:0.
- neg  out  1  result is negative (non-zero magnitude).
- ovf  out  1  magnitude ≥ 10^DIGITS; dec then holds magnitude mod 10^DIGITS.

## Operation
- Magnitude rule: if hex[DATA_W]=1, mag = (~hex[DATA_W-1:0] + 1) truncated to DATA_W bits; otherwise mag = hex[DATA_W-1:0]. A negative input with zero low bits gives mag 0; a negative input with only the low MSB set gives mag 2^(DATA_W-1).
- neg = sign AND (mag ≠ 0), captured at load.
- The FSM has three states: IDLE, CONV and DONE.
- IDLE: in_ready=1. On in_valid, load the shift register with mag, clear the BCD register and the ovf accumulator, latch neg, set cnt=DATA_W, and go to CONV.
- CONV: in_ready=0, out_valid=0. Each cycle, add 3 to every BCD digit that is ≥5. Then shift the {BCD, mag} register left by 1. OR the bit shifted out of the top digit into the ovf accumulator, and decrement cnt. On the cycle where cnt reaches 0 (after the shift), go to DONE.
- DONE: out_valid=1; dec, neg and ovf are stable.
  - out_ready=1 and in_valid=0: go to IDLE.
  - out_ready=1 and in_valid=1: in_ready=1 in this state only under out_ready, so the new word is loaded and the FSM goes straight to CONV (back-to-back).
  - out_ready=0: hold all outputs unchanged.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational from state and out_ready only, and never depends on in_valid.
- hex is sampled only on the accepting edge. Later changes to hex do not affect the conversion in flight.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, dec=0, neg=0, ovf=0, cnt=0.
- Latency: a word accepted at edge k gives out_valid=1 after edge k+DATA_W.
- Minimum spacing between accepts: DATA_W+1 edges (accept, DATA_W conversion edges, then accept again in DONE).
- dec, neg and ovf are registered. They may change only on a load edge or a CONV edge, and never while out_valid=1 and out_ready=0.
- When rst_n is asserted mid-conversion, all registers clear immediately, with no clock needed. After release, the first rising edge behaves as IDLE, and the interrupted word is discarded with no output.
- cnt width is clog2(DATA_W+1). The add-3 for every digit is done in the same cycle as the shift (one combinational layer per digit).

## Test plan
- Defaults. hex=0x03039 (12345) -> out_valid after 16 cycles; dec=0x12345, neg=0, ovf=0.
- Defaults, sign handling:
  - 0x1FFFF -> dec=0x00001, neg=1.
  - 0x18000 -> dec=0x32768, neg=1.
  - 0x10000 -> dec=0x00000, neg=0.
  - 0x0FFFF -> dec=0x65535, neg=0.
- DIGITS=4, hex=0x03039 -> dec=0x2345, ovf=1. Then hex=0x0270F (9999) -> dec=0x9999, ovf=0, confirming the sticky flag is cleared per word.
- Back-pressure and back-to-back. Hold out_ready=0 for 10 cycles after out_valid: outputs stay constant and in_ready=0. Then assert out_ready with in_valid high and the next word (hex=0x00007): the new word is accepted on the same edge, and dec=0x00007 appears 16 cycles later.
- Reset mid-operation. Pull rst_n low 5 cycles after accepting 12345: out_valid=0 and dec=0 immediately, in_ready=1 after release, and no stale result is ever presented.
- Randomised sweep at DATA_W=12 and DIGITS=4 against a reference model. Checks: no ovf for any input; latency exactly 12 cycles.
